// File: rtl/fp_add_pkg.sv
// Shared constants, field slices and FSM state type for the 16-bit FP adder.
package fp_add_pkg;

  localparam int EXP_W     = 5;
  localparam int FRAC_W    = 10;
  localparam int MAX_ALIGN = 12;

  // Unsigned significand with headroom bit, and its signed form for the add.
  localparam int SIG_W = FRAC_W + 2;
  localparam int SUM_W = FRAC_W + 3;
  // Alignment counter only needs to reach MAX_ALIGN.
  localparam int CNT_W = 4;

  localparam int SIGN_BIT = 15;
  localparam int EXP_HI   = 14;
  localparam int EXP_LO   = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // {headroom 0, implicit 1, stored fraction}
  function automatic logic [SIG_W-1:0] sig_of(input logic [15:0] w);
    return {1'b0, 1'b1, w[FRAC_W-1:0]};
  endfunction

endpackage

// File: rtl/fp_add_sequencer_if.sv
// Operand/result bundle for fp_add_sequencer.
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both high; valid, once raised, is held with its data until that edge.
interface fp_add_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        overflow;
  logic        underflow;
  logic        busy;

  // Operand source / result consumer side
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, busy
  );

  // Adder side
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, result, overflow, underflow, busy
  );
endinterface

// File: rtl/fp_align_shifter.sv
// Counted right-shift register used to align the smaller significand.
module fp_align_shifter
  import fp_add_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [SIG_W-1:0] load_val,
  input  logic [CNT_W-1:0] load_cnt,
  output logic [SIG_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Load value/count, or shift right by one (truncating) while count remains
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
      cnt   <= '0;
    end else if (load) begin
      value <= load_val;
      cnt   <= load_cnt;
    end else if (shift && cnt != '0) begin
      value <= value >> 1;
      cnt   <= cnt - CNT_W'(1);
    end
  end

  // High when a shift this cycle leaves the count at zero (alignment finishes)
  assign done = (cnt <= CNT_W'(1));

endmodule

// File: rtl/fp_add_sequencer.sv
// Multi-cycle half-precision adder: align, one signed add, serial normalise.
module fp_add_sequencer
  import fp_add_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  fp_add_sequencer_if.slave    bus,
  output state_t               state_dbg
);

  state_t state, state_nxt;

  logic             accept, out_hs;
  logic [EXP_W-1:0] exp_a, exp_b, exp_diff;
  logic             a_zero, b_zero, a_is_ref;
  logic [CNT_W-1:0] align_cnt;

  logic [SIG_W-1:0] ref_sig, mag;
  logic             ref_sign, oth_sign, rsign;
  logic [EXP_W-1:0] ref_exp, wexp, wexp_dn;
  logic [15:0]      result_q;
  logic             ovf_q, unf_q;

  logic [SIG_W-1:0] sh_val;
  logic             sh_done;

  logic [SUM_W-1:0] ref_t, oth_t, sum_t;
  logic             sum_neg;
  logic [SIG_W-1:0] sum_mag;

  assign accept   = bus.in_valid && bus.in_ready;
  assign out_hs   = bus.out_valid && bus.out_ready;
  assign exp_a    = bus.in_a[EXP_HI:EXP_LO];
  assign exp_b    = bus.in_b[EXP_HI:EXP_LO];
  assign a_zero   = (exp_a == '0);
  assign b_zero   = (exp_b == '0);
  assign a_is_ref = (exp_a >= exp_b);
  assign exp_diff = a_is_ref ? (exp_a - exp_b) : (exp_b - exp_a);
  assign align_cnt = (exp_diff > EXP_W'(MAX_ALIGN)) ? CNT_W'(MAX_ALIGN)
                                                    : exp_diff[CNT_W-1:0];

  fp_align_shifter u_align (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .shift    (state == ALIGN),
    .load_val (a_is_ref ? sig_of(bus.in_b) : sig_of(bus.in_a)),
    .load_cnt (align_cnt),
    .value    (sh_val),
    .done     (sh_done)
  );

  // Signed add of the reference and aligned significands, then magnitude
  always_comb begin
    ref_t   = ref_sign ? (SUM_W'(0) - {1'b0, ref_sig}) : {1'b0, ref_sig};
    oth_t   = oth_sign ? (SUM_W'(0) - {1'b0, sh_val})  : {1'b0, sh_val};
    sum_t   = ref_t + oth_t;
    sum_neg = sum_t[SUM_W-1];
    sum_mag = sum_neg ? SIG_W'(SUM_W'(0) - sum_t) : sum_t[SIG_W-1:0];
  end

  assign wexp_dn = wexp - EXP_W'(1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (a_zero || b_zero)     state_nxt = DONE;
          else if (align_cnt != '0) state_nxt = ALIGN;
          else                      state_nxt = ADD;
        end
      end
      ALIGN: if (sh_done) state_nxt = ADD;
      ADD:   state_nxt = (sum_mag == '0) ? DONE : NORM;
      NORM: begin
        if (mag[SIG_W-1])         state_nxt = DONE;
        else if (!mag[SIG_W-2])   state_nxt = (wexp_dn == '0) ? DONE : NORM;
        else                      state_nxt = DONE;
      end
      DONE:  if (out_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, add, normalisation steps and the held result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_sig  <= '0;
      ref_sign <= 1'b0;
      oth_sign <= 1'b0;
      ref_exp  <= '0;
      mag      <= '0;
      wexp     <= '0;
      rsign    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            ref_sig  <= a_is_ref ? sig_of(bus.in_a) : sig_of(bus.in_b);
            ref_exp  <= a_is_ref ? exp_a : exp_b;
            ref_sign <= a_is_ref ? bus.in_a[SIGN_BIT] : bus.in_b[SIGN_BIT];
            oth_sign <= a_is_ref ? bus.in_b[SIGN_BIT] : bus.in_a[SIGN_BIT];
            // A zero operand passes the other through; exp 0 fractions are ignored
            if (a_zero && b_zero) result_q <= 16'h0000;
            else if (a_zero)      result_q <= bus.in_b;
            else if (b_zero)      result_q <= bus.in_a;
          end
        end
        ADD: begin
          mag   <= sum_mag;
          wexp  <= ref_exp;
          rsign <= sum_neg;
          if (sum_mag == '0) result_q <= 16'h0000;
        end
        NORM: begin
          if (mag[SIG_W-1]) begin
            if (wexp == {EXP_W{1'b1}}) begin
              result_q <= {rsign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
              ovf_q    <= 1'b1;
            end else begin
              result_q <= {rsign, wexp + EXP_W'(1), mag[FRAC_W:1]};
            end
          end else if (!mag[SIG_W-2]) begin
            mag  <= mag << 1;
            wexp <= wexp_dn;
            if (wexp_dn == '0) begin
              result_q <= 16'h0000;
              unf_q    <= 1'b1;
            end
          end else begin
            result_q <= {rsign, wexp, mag[FRAC_W-1:0]};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.result    = result_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed-vector bench for fp_add_sequencer.
module tb_fp_add_sequencer;
  import fp_add_pkg::*;

  logic   clk;
  logic   reset;
  state_t state_dbg;

  fp_add_sequencer_if bus ();

  fp_add_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_ready"},  32'(bus.in_ready),  32'd1);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".busy"},      32'(bus.busy),      32'd0);
    check({tag, ".result"},    32'(bus.result),    32'h0000);
    check({tag, ".ovf"},       32'(bus.overflow),  32'd0);
    check({tag, ".unf"},       32'(bus.underflow), 32'd0);
  endtask

  // Called at a negedge; returns at a negedge with in_valid asserted
  task automatic wait_ready_and_drive(input string tag, input logic [15:0] a, input logic [15:0] b);
    int w;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
  endtask

  // One transaction: drive, measure latency, check result, optional hold, handshake
  task automatic run_txn(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_res, input logic exp_ovf,
                         input logic exp_unf, input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    wait_ready_and_drive(tag, a, b);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 100);
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".result"},  32'(bus.result),    32'(exp_res));
    check({tag, ".ovf"},     32'(bus.overflow),  32'(exp_ovf));
    check({tag, ".unf"},     32'(bus.underflow), 32'(exp_unf));
    // Hold off the consumer while a new operand pair is offered
    if (hold > 0) begin
      bus.in_a     = 16'h3C00;
      bus.in_b     = 16'h3C00;
      bus.in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, ".hold_valid"},  32'(bus.out_valid), 32'd1);
        check({tag, ".hold_ready"},  32'(bus.in_ready),  32'd0);
        check({tag, ".hold_result"}, 32'(bus.result),    32'(exp_res));
        check({tag, ".hold_ovf"},    32'(bus.overflow),  32'(exp_ovf));
      end
      bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check({tag, ".post_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".post_ready"}, 32'(bus.in_ready),  32'd1);
  endtask

  // Stimulus and final report
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle");

    run_txn("add_pos",   16'h44C0, 16'h4020, 16'h46D0, 1'b0, 1'b0, 4,  0);
    run_txn("add_neg",   16'h44C0, 16'hC020, 16'h4160, 1'b0, 1'b0, 5,  0);
    run_txn("cancel",    16'h44C0, 16'hC4C0, 16'h0000, 1'b0, 1'b0, 2,  0);
    run_txn("overflow",  16'h7FFF, 16'h7FFF, 16'h7C00, 1'b1, 1'b0, 3,  5);
    run_txn("zero_a",    16'h0000, 16'hC100, 16'hC100, 1'b0, 1'b0, 1,  0);
    run_txn("zero_b",    16'h4020, 16'h8000, 16'h4020, 1'b0, 1'b0, 1,  0);
    run_txn("zero_both", 16'h0000, 16'h0005, 16'h0000, 1'b0, 1'b0, 1,  0);
    run_txn("underflow", 16'h0C00, 16'h8BFF, 16'h0000, 1'b0, 1'b1, 6,  0);
    run_txn("neg_res",   16'hC4C0, 16'h4020, 16'hC160, 1'b0, 1'b0, 5,  0);
    run_txn("tie_a_ref", 16'h4400, 16'hC600, 16'hC000, 1'b0, 1'b0, 4,  0);
    run_txn("max_align", 16'h7800, 16'h2800, 16'h7800, 1'b0, 1'b0, 15, 0);

    // Abort a long alignment with reset
    @(negedge clk);
    wait_ready_and_drive("abort", 16'h7800, 16'h2800);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort.in_align", 32'(state_dbg), 32'(ALIGN));
    reset = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    reset = 1'b0;
    run_txn("after_abort", 16'h7800, 16'h2800, 16'h7800, 1'b0, 1'b0, 15, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
